// File: rtl/recog_pkg.sv
// Shared types and constants for the digit recognition frame sequencer.
package recog_pkg;

  localparam int unsigned RamAw = 11;
  localparam int unsigned RamDw = 11;

  localparam logic [1:0] FRAME_PROJ  = 2'd0;
  localparam logic [1:0] FRAME_LOCK  = 2'd1;
  localparam logic [1:0] FRAME_RECOG = 2'd2;
  localparam logic [1:0] FRAME_HOLD  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StProject,
    StArm,
    StLock,
    StRecog,
    StPresent
  } state_e;

  function automatic logic [1:0] frame_of(state_e st);
    logic [1:0] fc;
    fc = FRAME_PROJ;
    case (st)
      StLock:    fc = FRAME_LOCK;
      StRecog:   fc = FRAME_RECOG;
      StPresent: fc = FRAME_HOLD;
      default:   fc = FRAME_PROJ;
    endcase
    return fc;
  endfunction

  // Borders are considered locked only while the recognizer frames run.
  function automatic logic flag_of(state_e st);
    return (st == StLock) || (st == StRecog);
  endfunction

endpackage

// File: rtl/border_ram_arb.sv
// Combinational arbiter for the single border-RAM port: projection writes vs recognizer reads.
module border_ram_arb
  import recog_pkg::*;
(
  input  logic             rst_i,
  input  logic             proj_phase_i,
  input  logic             flag_i,
  input  logic             proj_wr_req_i,
  input  logic [RamAw-1:0] proj_wr_addr_i,
  input  logic [RamDw-1:0] proj_wr_data_i,
  input  logic             rec_rd_req_i,
  input  logic [RamAw-1:0] rec_rd_addr_i,
  output logic             proj_wr_gnt_o,
  output logic             rec_rd_gnt_o,
  output logic             ram_we_o,
  output logic [RamAw-1:0] ram_addr_o,
  output logic [RamDw-1:0] ram_wdata_o
);

  logic wr_gnt;
  logic rd_gnt;

  // Reset masks the grants so a write in flight when rst rises never lands.
  assign wr_gnt = proj_wr_req_i & proj_phase_i & ~flag_i & ~rst_i;
  assign rd_gnt = rec_rd_req_i & flag_i & ~rst_i;

  always_comb begin
    proj_wr_gnt_o = wr_gnt;
    rec_rd_gnt_o  = rd_gnt;
    ram_we_o      = wr_gnt;
    ram_addr_o    = '0;
    ram_wdata_o   = '0;
    if (wr_gnt) begin
      ram_addr_o  = proj_wr_addr_i;
      ram_wdata_o = proj_wr_data_i;
    end else if (rd_gnt) begin
      ram_addr_o  = rec_rd_addr_i;
    end
  end

endmodule

// File: rtl/recog_frame_ctrl.sv
// Frame sequencer: projection -> border lock -> recognition -> result handoff, with RAM arbitration.
module recog_frame_ctrl
  import recog_pkg::*;
#(
  parameter int unsigned NUM_ROW   = 1,
  parameter int unsigned NUM_COL   = 4,
  parameter int unsigned DIGIT_W   = NUM_ROW * NUM_COL * 4,
  parameter int unsigned MAX_RETRY = 7
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic               frame_start_i,
  input  logic               frame_end_i,
  input  logic [3:0]         proj_num_row_i,
  input  logic [3:0]         proj_num_col_i,
  input  logic               proj_wr_req_i,
  input  logic [RamAw-1:0]   proj_wr_addr_i,
  input  logic [RamDw-1:0]   proj_wr_data_i,
  input  logic               rec_rd_req_i,
  input  logic [RamAw-1:0]   rec_rd_addr_i,
  output logic               proj_wr_gnt_o,
  output logic               rec_rd_gnt_o,
  output logic               ram_we_o,
  output logic [RamAw-1:0]   ram_addr_o,
  output logic [RamDw-1:0]   ram_wdata_o,
  output logic [1:0]         frame_cnt_o,
  output logic               project_done_flag_o,
  output logic [3:0]         num_row_o,
  output logic [3:0]         num_col_o,
  input  logic [DIGIT_W-1:0] digit_in_i,
  output logic [DIGIT_W-1:0] result_o,
  output logic               result_valid_o,
  input  logic               result_ready_i,
  output logic               err_o
);

  localparam int unsigned RetryW = $clog2(MAX_RETRY + 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [3:0] MaxRow = 4'(NUM_ROW);
  localparam logic [3:0] MaxCol = 4'(NUM_COL);

  state_e              state_q, state_d;
  logic                pend_q, pend_d;
  logic [1:0]          frame_cnt_q, frame_cnt_d;
  logic                flag_q, flag_d;
  logic [3:0]          num_row_q, num_row_d;
  logic [3:0]          num_col_q, num_col_d;
  logic [DIGIT_W-1:0]  result_q, result_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [RetryW-1:0]   retry_q, retry_d;

  logic start_eff;
  logic counts_ok;

  // A start coinciding with an end is deferred one cycle so the end action wins.
  assign start_eff = (frame_start_i | pend_q) & ~frame_end_i;
  assign counts_ok = (proj_num_row_i != 4'd0) && (proj_num_col_i != 4'd0) &&
                     (proj_num_row_i <= MaxRow) && (proj_num_col_i <= MaxCol);

  always_comb begin
    state_d   = state_q;
    pend_d    = frame_end_i & (frame_start_i | pend_q);
    num_row_d = num_row_q;
    num_col_d = num_col_q;
    result_d  = result_q;
    valid_d   = valid_q;
    err_d     = err_q;
    retry_d   = retry_q;

    if (valid_q && result_ready_i) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        if (start_eff && en_i) begin
          state_d = StProject;
        end
      end
      StProject: begin
        if (frame_end_i) begin
          if (counts_ok) begin
            num_row_d = proj_num_row_i;
            num_col_d = proj_num_col_i;
            retry_d   = '0;
            state_d   = StArm;
          end else begin
            if (retry_q != RetryMax) begin
              retry_d = retry_q + RetryW'(1);
            end
            if (retry_d == RetryMax) begin
              err_d = 1'b1;
            end
          end
        end else if (start_eff && !en_i) begin
          state_d = StIdle;
        end
      end
      StArm: begin
        if (start_eff) begin
          state_d = en_i ? StLock : StIdle;
        end
      end
      StLock: begin
        if (start_eff) begin
          state_d = en_i ? StRecog : StIdle;
        end
      end
      StRecog: begin
        if (frame_end_i) begin
          result_d = digit_in_i;
          valid_d  = 1'b1;
          state_d  = StPresent;
        end else if (start_eff && !en_i) begin
          state_d = StIdle;
        end
      end
      StPresent: begin
        // Starts seen while the result is still pending are consumed, skipping that frame.
        if (start_eff && !valid_q) begin
          state_d = en_i ? StProject : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    frame_cnt_d = frame_of(state_d);
    flag_d      = flag_of(state_d);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      pend_q      <= 1'b0;
      frame_cnt_q <= FRAME_PROJ;
      flag_q      <= 1'b0;
      num_row_q   <= '0;
      num_col_q   <= '0;
      result_q    <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      retry_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      frame_cnt_q <= frame_cnt_d;
      flag_q      <= flag_d;
      num_row_q   <= num_row_d;
      num_col_q   <= num_col_d;
      result_q    <= result_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      retry_q     <= retry_d;
    end
  end

  border_ram_arb u_arb (
    .rst_i          (rst_i),
    .proj_phase_i   (state_q == StProject),
    .flag_i         (flag_q),
    .proj_wr_req_i  (proj_wr_req_i),
    .proj_wr_addr_i (proj_wr_addr_i),
    .proj_wr_data_i (proj_wr_data_i),
    .rec_rd_req_i   (rec_rd_req_i),
    .rec_rd_addr_i  (rec_rd_addr_i),
    .proj_wr_gnt_o  (proj_wr_gnt_o),
    .rec_rd_gnt_o   (rec_rd_gnt_o),
    .ram_we_o       (ram_we_o),
    .ram_addr_o     (ram_addr_o),
    .ram_wdata_o    (ram_wdata_o)
  );

  assign frame_cnt_o         = frame_cnt_q;
  assign project_done_flag_o = flag_q;
  assign num_row_o           = num_row_q;
  assign num_col_o           = num_col_q;
  assign result_o            = result_q;
  assign result_valid_o      = valid_q;
  assign err_o               = err_q;

endmodule

// File: tb/tb_recog_frame_ctrl.sv
// Self-checking bench for recog_frame_ctrl: frame table plus hand-written corner sequences.
module tb_recog_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst, en, frame_start, frame_end;
  logic [3:0]  proj_num_row, proj_num_col;
  logic        proj_wr_req, rec_rd_req;
  logic [10:0] proj_wr_addr, proj_wr_data, rec_rd_addr;
  logic        proj_wr_gnt, rec_rd_gnt, ram_we;
  logic [10:0] ram_addr, ram_wdata;
  logic [1:0]  frame_cnt;
  logic        flag;
  logic [3:0]  num_row, num_col;
  logic [15:0] digit_in, result;
  logic        result_valid, result_ready, err;

  int checks = 0;
  int errors = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;

  recog_frame_ctrl dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .en_i                (en),
    .frame_start_i       (frame_start),
    .frame_end_i         (frame_end),
    .proj_num_row_i      (proj_num_row),
    .proj_num_col_i      (proj_num_col),
    .proj_wr_req_i       (proj_wr_req),
    .proj_wr_addr_i      (proj_wr_addr),
    .proj_wr_data_i      (proj_wr_data),
    .rec_rd_req_i        (rec_rd_req),
    .rec_rd_addr_i       (rec_rd_addr),
    .proj_wr_gnt_o       (proj_wr_gnt),
    .rec_rd_gnt_o        (rec_rd_gnt),
    .ram_we_o            (ram_we),
    .ram_addr_o          (ram_addr),
    .ram_wdata_o         (ram_wdata),
    .frame_cnt_o         (frame_cnt),
    .project_done_flag_o (flag),
    .num_row_o           (num_row),
    .num_col_o           (num_col),
    .digit_in_i          (digit_in),
    .result_o            (result),
    .result_valid_o      (result_valid),
    .result_ready_i      (result_ready),
    .err_o               (err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_start(input logic e);
    en = e;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  // Result scoreboard: popped whenever a handshake is seen.
  always @(negedge clk) begin
    if (!rst && result_valid && result_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got %h expected none", result);
      end else begin
        chk("sb_result", 32'(result), 32'(sb.pop_front()));
      end
    end
  end

  typedef struct {
    logic        en;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [15:0] digit;
    logic        rdy;
    logic [1:0]  fc_s;
    logic [1:0]  fc_e;
    logic        fl_s;
    logic        v_e;
  } frame_vec_t;

  frame_vec_t tbl[13];

  initial begin
    rst = 1'b1; en = 1'b0; frame_start = 1'b0; frame_end = 1'b0;
    proj_num_row = '0; proj_num_col = '0; proj_wr_req = 1'b0; rec_rd_req = 1'b0;
    proj_wr_addr = '0; proj_wr_data = '0; rec_rd_addr = '0; digit_in = '0;
    result_ready = 1'b1;

    //           en    row   col   digit     rdy   fc_s  fc_e  fl_s  v_e
    tbl[0]  = '{1'b1, 4'd1, 4'd4, 16'h0000, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'd0, 4'd0, 16'h0000, 1'b1, 2'd1, 2'd1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 4'd0, 4'd0, 16'h1234, 1'b1, 2'd2, 2'd3, 1'b1, 1'b1};
    tbl[3]  = '{1'b1, 4'd1, 4'd2, 16'h0000, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 4'd0, 4'd0, 16'h0000, 1'b0, 2'd1, 2'd1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 4'd0, 4'd0, 16'hABCD, 1'b0, 2'd2, 2'd3, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 4'd0, 4'd0, 16'h0000, 1'b0, 2'd3, 2'd3, 1'b0, 1'b1};
    tbl[7]  = '{1'b1, 4'd0, 4'd0, 16'h0000, 1'b0, 2'd3, 2'd3, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 4'd0, 4'd0, 16'h0000, 1'b0, 2'd3, 2'd3, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 4'd0, 4'd0, 16'h0000, 1'b1, 2'd3, 2'd3, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 4'd1, 4'd4, 16'h0000, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 4'd0, 4'd0, 16'h0000, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 4'd1, 4'd4, 16'h0000, 1'b1, 2'd0, 2'd0, 1'b0, 1'b0};

    step();
    step();
    rst = 1'b0;

    // Reset state, with requests active in IDLE.
    proj_wr_req = 1'b1; proj_wr_addr = 11'd5; rec_rd_req = 1'b1; rec_rd_addr = 11'd9;
    #1;
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_flag", 32'(flag), 32'd0);
    chk("rst_num_row", 32'(num_row), 32'd0);
    chk("rst_num_col", 32'(num_col), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("idle_ram_we", 32'(ram_we), 32'd0);
    chk("idle_ram_addr", 32'(ram_addr), 32'd0);
    chk("idle_rd_gnt", 32'(rec_rd_gnt), 32'd0);
    proj_wr_req = 1'b0; rec_rd_req = 1'b0;
    step();

    for (int i = 0; i < 13; i++) begin
      en = tbl[i].en;
      result_ready = tbl[i].rdy;
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      chk($sformatf("v%0d_fc_start", i), 32'(frame_cnt), 32'(tbl[i].fc_s));
      chk($sformatf("v%0d_flag_start", i), 32'(flag), 32'(tbl[i].fl_s));
      step();
      step();
      proj_num_row = tbl[i].row; proj_num_col = tbl[i].col; digit_in = tbl[i].digit;
      frame_end = 1'b1;
      if (tbl[i].fc_s == 2'd2) sb.push_back(tbl[i].digit);
      step();
      frame_end = 1'b0;
      chk($sformatf("v%0d_fc_end", i), 32'(frame_cnt), 32'(tbl[i].fc_e));
      chk($sformatf("v%0d_valid_end", i), 32'(result_valid), 32'(tbl[i].v_e));
      step();
    end
    chk("latched_num_row", 32'(num_row), 32'd1);
    chk("latched_num_col", 32'(num_col), 32'd4);

    // Arbitration: now in ARM with en=1.
    proj_wr_req = 1'b1; proj_wr_addr = 11'd5; proj_wr_data = 11'd7;
    rec_rd_req = 1'b1; rec_rd_addr = 11'd9;
    #1;
    chk("arm_ram_we", 32'(ram_we), 32'd0);
    pulse_start(1'b1);
    chk("lock_ram_we", 32'(ram_we), 32'd0);
    chk("lock_wr_gnt", 32'(proj_wr_gnt), 32'd0);
    chk("lock_rd_gnt", 32'(rec_rd_gnt), 32'd1);
    chk("lock_ram_addr", 32'(ram_addr), 32'd9);
    do_reset();
    chk("rst_lock_ram_we", 32'(ram_we), 32'd0);
    chk("rst_lock_rd_gnt", 32'(rec_rd_gnt), 32'd0);
    pulse_start(1'b1);
    chk("proj_ram_we", 32'(ram_we), 32'd1);
    chk("proj_wr_gnt", 32'(proj_wr_gnt), 32'd1);
    chk("proj_ram_addr", 32'(ram_addr), 32'd5);
    chk("proj_ram_wdata", 32'(ram_wdata), 32'd7);
    chk("proj_rd_gnt", 32'(rec_rd_gnt), 32'd0);
    proj_wr_req = 1'b0; rec_rd_req = 1'b0;

    // Bad counts for seven frames while in PROJECT.
    for (int i = 0; i < 7; i++) begin
      pulse_start(1'b1);
      step();
      proj_num_row = 4'd1; proj_num_col = 4'd5; frame_end = 1'b1;
      step();
      frame_end = 1'b0;
      chk($sformatf("bad%0d_err", i), 32'(err), (i == 6) ? 32'd1 : 32'd0);
      chk($sformatf("bad%0d_flag", i), 32'(flag), 32'd0);
      step();
    end
    pulse_start(1'b1);
    chk("bad_stay_project_fc", 32'(frame_cnt), 32'd0);
    chk("bad_stay_project_flag", 32'(flag), 32'd0);
    chk("err_sticky", 32'(err), 32'd1);

    // Coincident start and end in PROJECT with good counts.
    do_reset();
    chk("err_cleared", 32'(err), 32'd0);
    pulse_start(1'b1);
    step();
    proj_num_row = 4'd1; proj_num_col = 4'd3;
    frame_start = 1'b1; frame_end = 1'b1;
    step();
    frame_start = 1'b0; frame_end = 1'b0;
    chk("coinc_arm_fc", 32'(frame_cnt), 32'd0);
    chk("coinc_arm_flag", 32'(flag), 32'd0);
    chk("coinc_num_col", 32'(num_col), 32'd3);
    step();
    chk("coinc_lock_fc", 32'(frame_cnt), 32'd1);
    chk("coinc_lock_flag", 32'(flag), 32'd1);

    // Reset in the middle of RECOG.
    step();
    pulse_start(1'b1);
    chk("recog_fc", 32'(frame_cnt), 32'd2);
    step();
    digit_in = 16'h5678;
    rst = 1'b1;
    step();
    chk("midrst_fc", 32'(frame_cnt), 32'd0);
    chk("midrst_flag", 32'(flag), 32'd0);
    chk("midrst_num_row", 32'(num_row), 32'd0);
    chk("midrst_num_col", 32'(num_col), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_valid", 32'(result_valid), 32'd0);
    rst = 1'b0;
    step();
    step();
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/recog_frame_ctrl.md
# recog_frame_ctrl

Frame-level sequencer for the digit recognition pipeline. It steps the pipeline through three frames: projection, border lock and feature recognition. It drives `frame_cnt` and `project_done_flag` into the recognizer and arbitrates the single border-RAM port between the projection writer and the recognizer reader. It validates the digit counts found by projection, captures the recognized digit word, and presents it downstream with a valid/ready handshake.

## Interface
Parameters:
- NUM_ROW, 1: maximum digit rows.
- NUM_COL, 4: maximum digit columns.
- DIGIT_W, NUM_ROW*NUM_COL*4: width of the digit word (4 bits per digit).
- MAX_RETRY, 7: consecutive failed projection frames before `err` is raised.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable; sampled on `frame_start`.
- frame_start  in  1  one-cycle pulse at the first pixel of a frame.
- frame_end  in  1  one-cycle pulse after the last pixel of a frame.
- proj_num_row / proj_num_col  in  4 each  counts found by projection; valid when `frame_end` is high.
- proj_wr_req  in  1  projection writer request; proj_wr_addr in 11; proj_wr_data in 11.
- rec_rd_req  in  1  recognizer read request; rec_rd_addr in 11.
- proj_wr_gnt / rec_rd_gnt  out  1 each  grants.
- ram_we  out  1; ram_addr  out  11; ram_wdata  out  11  border-RAM port.
- frame_cnt  out  2  pipeline frame index.
- project_done_flag  out  1  borders locked.
- num_row / num_col  out  4 each  locked counts.
- digit_in  in  DIGIT_W  recognizer result.
- result  out  DIGIT_W; result_valid  out  1; result_ready  in  1.
- err  out  1  sticky flag: retry limit exceeded.

## Operation
- FSM states are IDLE, PROJECT, ARM, LOCK, RECOG, PRESENT. Every transition except PROJECT→ARM and RECOG→PRESENT fires only on `frame_start`.
- IDLE: `frame_cnt` = 0, flag = 0. On `frame_start` with `en`=1, go to PROJECT.
- PROJECT: `frame_cnt` = 0, flag = 0. On `frame_end`, the counts are OK when both are nonzero, `proj_num_row` ≤ NUM_ROW and `proj_num_col` ≤ NUM_COL.
  - OK: latch `num_row`/`num_col`, clear `retry_cnt`, go to ARM.
  - Not OK: increment `retry_cnt` (saturating) and stay in PROJECT. Set `err` when `retry_cnt` reaches MAX_RETRY.
- ARM: `frame_cnt` = 0, flag = 0. Go to LOCK on the next `frame_start`.
- LOCK: `frame_cnt` = 1, flag = 1. Go to RECOG on `frame_start`.
- RECOG: `frame_cnt` = 2, flag = 1. On `frame_end`, capture `result` ← `digit_in`, set `result_valid` = 1, go to PRESENT.
- PRESENT: `frame_cnt` = 3, flag = 0. Leave on `frame_start` only once `result_valid` = 0:
  - `en`=1 → PROJECT.
  - `en`=0 → IDLE.
  - If `result_valid` is still 1, stay in PRESENT; whole frames are skipped.
- `en`=0 sampled on any `frame_start` outside PRESENT → IDLE. `num_row`/`num_col` are kept; `result` is kept.
- Arbitration:
  - `proj_wr_gnt` = `proj_wr_req` && state == PROJECT.
  - `rec_rd_gnt` = `rec_rd_req` && flag.
  - `ram_we` = `proj_wr_gnt`.
  - `ram_addr` = `proj_wr_addr` when writing, else `rec_rd_addr`.
  - No RAM write is possible while flag = 1.
- Handshake: `result` and `result_valid` are stable until `result_valid` && `result_ready`. The handshake clears `result_valid` on the next edge.
- `err` is cleared only by `rst`.

## Timing
- All outputs registered except the grants and RAM port, which are combinational from requests and registered state.
- Reset values: state IDLE, `frame_cnt` 0, flag 0, `num_row`/`num_col` 0, `result` 0, `result_valid` 0, `err` 0, `retry_cnt` 0. Grants, `ram_we`, `ram_addr` and `ram_wdata` are 0 in IDLE.
- `frame_cnt` and flag change on the edge after the `frame_start` cycle, i.e. 1-cycle latency.
- `result_valid` rises one cycle after the RECOG `frame_end`.
- `frame_start` and `frame_end` in the same cycle: the `frame_end` action applies. `frame_start` is stored in a 1-bit pending register and acted on the next cycle. The pending bit is cleared by `rst` or when consumed.
- `rst` mid-frame: immediate return to the reset values. Any in-progress RAM write is dropped.

## Structure
- Package `recog_pkg`: state enum, FRAME_PROJ=0, FRAME_LOCK=1, FRAME_RECOG=2, FRAME_HOLD=3.
- One sub-module, `border_ram_arb`: the combinational grant and port mux with the flag as input.

## Test plan
- Nominal run: `en`=1, projection reports 1×4, `digit_in`=16'h1234 at the RECOG `frame_end`.
  - `frame_cnt` sequence 0,0,1,2,3.
  - `result`=16'h1234 with `result_valid` high on the cycle after that `frame_end`.
  - `num_col`=4.
- Bad counts: projection reports `proj_num_col`=5 for 7 consecutive frames.
  - `err`=1 after the 7th `frame_end`.
  - State remains PROJECT; flag never rises.
- Back-pressure: `result_ready`=0 for 3 frames.
  - `result` is held and `frame_cnt` stays 3.
  - Set `result_ready`=1: handshake completes, then PROJECT at the next `frame_start`.
- Arbitration: `proj_wr_req`=1 with addr 5 during LOCK → `ram_we`=0, `proj_wr_gnt`=0. During PROJECT → `ram_we`=1, `ram_addr`=5.
- Coincident pulses: `frame_end` and `frame_start` together in PROJECT with good counts → ARM, then LOCK one cycle later, `frame_cnt`=1.
- `rst`=1 mid-RECOG → all outputs at reset values on the next edge; `result_valid`=0.
